frame_line_fetcher: RTL and testbench

//  Downstream consumer of ddr2_mgr's frame_buffer read port. At each frame start it walks a

---
 rtl/frame_line_fetcher_pkg.sv | 24 ++
 rtl/frame_line_fetcher_if.sv | 24 ++
 rtl/frame_line_fetcher_fifo.sv | 57 +++++
 rtl/frame_line_fetcher.sv | 148 ++++++++++++++
 tb/tb_frame_line_fetcher.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/frame_line_fetcher_pkg.sv
// rtl/frame_line_fetcher_pkg.sv - shared widths, defaults and FSM encoding for the line fetcher
package frame_line_fetcher_pkg;

   localparam int                    DEF_ADDR_W      = 25;
   localparam int                    XFR_LEN_W       = 10;
   localparam logic [XFR_LEN_W-1:0]  DEF_XFR_LEN     = 10'h140;
   localparam int                    DEF_LINES       = 480;
   localparam logic [DEF_ADDR_W-1:0] DEF_LINE_STRIDE = 25'h00A00;
   localparam int                    DEF_FIFO_AW     = 10;
   localparam int                    PIX_W           = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_REQ   = 3'd2,
      ST_XFER  = 3'd3,
      ST_LDONE = 3'd4
   } fetch_state_t;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/frame_line_fetcher_if.sv
// rtl/frame_line_fetcher_if.sv - DDR read port and pixel stream bundle
interface frame_line_fetcher_if #(
   parameter int ADDR_W = 25
) ();
   logic              rd_mem_req;
   logic [ADDR_W-1:0] rd_mem_addr;
   logic [9:0]        rd_xfr_len;
   logic              rd_mem_grant;
   logic [31:0]       rd_data;
   logic              rd_data_valid;
   logic [31:0]       pix_data;
   logic              pix_valid;
   logic              pix_ready;

   modport master (
      output rd_mem_req, rd_mem_addr, rd_xfr_len, pix_data, pix_valid,
      input  rd_mem_grant, rd_data, rd_data_valid, pix_ready
   );

   modport slave (
      input  rd_mem_req, rd_mem_addr, rd_xfr_len, pix_data, pix_valid,
      output rd_mem_grant, rd_data, rd_data_valid, pix_ready
   );
endinterface

// File: rtl/frame_line_fetcher_fifo.sv
// rtl/frame_line_fetcher_fifo.sv - first-word-fall-through sync FIFO with fill count and flush
module frame_line_fetcher_fifo #(
   parameter int DW = 32,
   parameter int AW = 10
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_flush,
   input  logic          i_push,
   input  logic [DW-1:0] i_data,
   input  logic          i_pop,
   output logic [DW-1:0] o_data,
   output logic          o_valid,
   output logic          o_full,
   output logic [AW:0]   o_fill
);
   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   logic [DW-1:0] r_mem [2**AW];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_fill;
   logic          w_push;
   logic          w_pop;

   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop & o_valid;

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_fill <= r_fill + 1'b1;
            2'b01:   r_fill <= r_fill - 1'b1;
            default: r_fill <= r_fill;
         endcase
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_valid = (r_fill != '0);
   assign o_full  = (r_fill == DEPTH);
   assign o_fill  = r_fill;
endmodule

// File: rtl/frame_line_fetcher.sv
// rtl/frame_line_fetcher.sv - walks a frame line by line over the DDR read port into a pixel FIFO
// A line is requested only when the FIFO can absorb the whole burst, since DDR reads cannot stall.
import frame_line_fetcher_pkg::*;

module frame_line_fetcher #(
   parameter int                    ADDR_W      = DEF_ADDR_W,
   parameter logic [XFR_LEN_W-1:0]  XFR_LEN     = DEF_XFR_LEN,
   parameter int                    LINES       = DEF_LINES,
   parameter logic [ADDR_W-1:0]     LINE_STRIDE = DEF_LINE_STRIDE,
   parameter int                    FIFO_AW     = DEF_FIFO_AW
) (
   input  logic                i_clk0,
   input  logic                i_rst0_n,
   input  logic                i_frame_start,
   input  logic [ADDR_W-1:0]   i_frame_base_addr,
   frame_line_fetcher_if.master io_bus,
   output logic                o_frame_busy,
   output logic                o_overflow_err,
   output logic                o_underrun_err
);
   localparam int                   LW        = cnt_width(LINES);
   localparam logic [LW-1:0]        LAST_LINE = LW'(LINES - 1);
   localparam logic [XFR_LEN_W-1:0] LAST_BEAT = XFR_LEN - 10'd1;
   localparam logic [FIFO_AW:0]     DEPTH     = {1'b1, {FIFO_AW{1'b0}}};

   fetch_state_t            r_state;
   fetch_state_t            w_state_nxt;
   logic [ADDR_W-1:0]       r_line_addr;
   logic [LW-1:0]           r_line_cnt;
   logic [XFR_LEN_W-1:0]    r_beat_cnt;
   logic                    r_pend;
   logic [ADDR_W-1:0]       r_pend_base;
   logic                    r_ovf;
   logic                    r_udr;

   logic                    w_restart;
   logic [ADDR_W-1:0]       w_restart_base;
   logic                    w_set_pend;
   logic                    w_push;
   logic                    w_fifo_full;
   logic [FIFO_AW:0]        w_fill;
   logic [FIFO_AW:0]        w_free;
   logic                    w_room;
   logic                    w_beat;

   assign w_free = DEPTH - w_fill;
   assign w_room = (32'(w_free) >= 32'(XFR_LEN));
   assign w_beat = (r_state == ST_XFER) & io_bus.rd_data_valid;
   assign w_push = w_beat & ~w_fifo_full;

   always_comb begin
      w_state_nxt    = r_state;
      w_restart      = 1'b0;
      w_restart_base = i_frame_base_addr;
      w_set_pend     = 1'b0;
      unique case (r_state)
         ST_IDLE: w_restart = i_frame_start;
         ST_WAIT: begin
            if (i_frame_start) w_restart = 1'b1;
            else if (w_room)   w_state_nxt = ST_REQ;
         end
         ST_REQ: begin
            if (io_bus.rd_mem_grant) begin
               w_state_nxt = ST_XFER;
               w_set_pend  = i_frame_start;
            end else if (i_frame_start) begin
               w_restart = 1'b1;
            end
         end
         ST_XFER: begin
            w_set_pend = i_frame_start;
            if (io_bus.rd_data_valid && r_beat_cnt == LAST_BEAT) w_state_nxt = ST_LDONE;
         end
         ST_LDONE: begin
            // A restart requested during the burst is honoured only once its beats have landed
            if (i_frame_start || r_pend) begin
               w_restart = 1'b1;
               if (!i_frame_start) w_restart_base = r_pend_base;
            end else if (r_line_cnt == LAST_LINE) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_WAIT;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (w_restart) w_state_nxt = ST_WAIT;
   end

   always_ff @(posedge i_clk0 or negedge i_rst0_n) begin
      if (!i_rst0_n) begin
         r_state     <= ST_IDLE;
         r_line_addr <= '0;
         r_line_cnt  <= '0;
         r_beat_cnt  <= '0;
         r_pend      <= 1'b0;
         r_pend_base <= '0;
         r_ovf       <= 1'b0;
         r_udr       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_restart) begin
            r_line_addr <= w_restart_base;
            r_line_cnt  <= '0;
            r_pend      <= 1'b0;
         end else if (r_state == ST_LDONE) begin
            r_line_addr <= r_line_addr + LINE_STRIDE;
            r_line_cnt  <= r_line_cnt + 1'b1;
         end
         if (w_set_pend) begin
            r_pend      <= 1'b1;
            r_pend_base <= i_frame_base_addr;
         end
         if (r_state == ST_REQ && io_bus.rd_mem_grant) r_beat_cnt <= '0;
         else if (w_beat)                              r_beat_cnt <= r_beat_cnt + 1'b1;
         if (w_restart) begin
            r_ovf <= 1'b0;
            r_udr <= 1'b0;
         end else begin
            if (w_beat && w_fifo_full) r_ovf <= 1'b1;
            if (io_bus.pix_ready && !io_bus.pix_valid && o_frame_busy) r_udr <= 1'b1;
         end
      end
   end

   frame_line_fetcher_fifo #(
      .DW (PIX_W),
      .AW (FIFO_AW)
   ) u_fifo (
      .i_clk   (i_clk0),
      .i_rst_n (i_rst0_n),
      .i_flush (w_restart),
      .i_push  (w_push),
      .i_data  (io_bus.rd_data),
      .i_pop   (io_bus.pix_ready),
      .o_data  (io_bus.pix_data),
      .o_valid (io_bus.pix_valid),
      .o_full  (w_fifo_full),
      .o_fill  (w_fill)
   );

   assign io_bus.rd_mem_req  = (r_state == ST_REQ);
   assign io_bus.rd_mem_addr = r_line_addr;
   assign io_bus.rd_xfr_len  = XFR_LEN;
   assign o_frame_busy       = (r_state != ST_IDLE);
   assign o_overflow_err     = r_ovf;
   assign o_underrun_err     = r_udr;
endmodule

// File: tb/tb_frame_line_fetcher.sv
// tb/tb_frame_line_fetcher.sv - directed self-checking bench for frame_line_fetcher
// DUT runs with XFR_LEN=4, LINES=3, FIFO depth 8 so every corner is reached quickly.
module tb_frame_line_fetcher;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fs = 1'b0;
   logic [24:0] base = '0;
   logic        busy;
   logic        ovf;
   logic        udr;
   int          n_cmp = 0;
   int          n_bad = 0;

   frame_line_fetcher_if #(.ADDR_W(25)) bus ();

   frame_line_fetcher #(
      .ADDR_W      (25),
      .XFR_LEN     (10'd4),
      .LINES       (3),
      .LINE_STRIDE (25'h00A00),
      .FIFO_AW     (3)
   ) dut (
      .i_clk0            (clk),
      .i_rst0_n          (rst_n),
      .i_frame_start     (fs),
      .i_frame_base_addr (base),
      .io_bus            (bus.master),
      .o_frame_busy      (busy),
      .o_overflow_err    (ovf),
      .o_underrun_err    (udr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_req(input string tag, input logic [24:0] a);
      int n = 0;
      while (bus.rd_mem_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_req"}, 64'(bus.rd_mem_req), 64'd1);
      chk({tag, "_addr"}, 64'(bus.rd_mem_addr), 64'(a));
   endtask

   task automatic grant_burst(input string tag);
      tick();
      tick();
      bus.rd_mem_grant = 1'b1;
      tick();
      bus.rd_mem_grant = 1'b0;
      chk({tag, "_req_drop"}, 64'(bus.rd_mem_req), 64'd0);
   endtask

   task automatic send_beats(input logic [31:0] d0, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         bus.rd_data       = d0 + 32'(i);
         bus.rd_data_valid = 1'b1;
         tick();
         bus.rd_data_valid = 1'b0;
         repeat (gap) tick();
      end
   endtask

   initial begin
      bus.rd_mem_grant  = 1'b0;
      bus.rd_data       = '0;
      bus.rd_data_valid = 1'b0;
      bus.pix_ready     = 1'b0;
      repeat (3) tick();

      chk("rst_req", 64'(bus.rd_mem_req), 64'd0);
      chk("rst_addr", 64'(bus.rd_mem_addr), 64'd0);
      chk("rst_pix_valid", 64'(bus.pix_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
      chk("rst_udr", 64'(udr), 64'd0);
      chk("xfr_len", 64'(bus.rd_xfr_len), 64'd4);
      rst_n = 1'b1;
      tick();

      bus.rd_mem_grant = 1'b1;
      tick();
      bus.rd_mem_grant = 1'b0;
      chk("idle_grant_req", 64'(bus.rd_mem_req), 64'd0);
      chk("idle_grant_busy", 64'(busy), 64'd0);

      // frame of three lines; the third must wait for room in the FIFO
      base = 25'h0;
      fs   = 1'b1;
      tick();
      fs   = 1'b0;
      chk("f1_busy", 64'(busy), 64'd1);
      wait_req("f1_l0", 25'h0);
      grant_burst("f1_l0");
      send_beats(32'h100, 4, 0);
      wait_req("f1_l1", 25'h00A00);
      grant_burst("f1_l1");
      send_beats(32'h110, 4, 0);
      repeat (5) tick();
      chk("full_no_req", 64'(bus.rd_mem_req), 64'd0);
      bus.pix_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("pop_head", 64'(bus.pix_data), 64'(32'h100 + 32'(i)));
         tick();
      end
      chk("room3_no_req", 64'(bus.rd_mem_req), 64'd0);
      chk("pop_head4", 64'(bus.pix_data), 64'h103);
      tick();
      bus.pix_ready = 1'b0;
      wait_req("f1_l2", 25'h01400);
      grant_burst("f1_l2");
      send_beats(32'h120, 4, 0);
      chk("ldone_busy", 64'(busy), 64'd1);
      tick();
      chk("frame_end_busy", 64'(busy), 64'd0);
      bus.pix_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("drain", 64'(bus.pix_data), (i < 4) ? 64'(32'h110 + 32'(i)) : 64'(32'h11C + 32'(i)));
         tick();
      end
      chk("drain_empty", 64'(bus.pix_valid), 64'd0);
      tick();
      tick();
      chk("idle_no_udr", 64'(udr), 64'd0);
      chk("f1_no_ovf", 64'(ovf), 64'd0);
      bus.pix_ready = 1'b0;

      // restart requested twice mid-burst; the later base wins after the burst
      base = 25'h2000;
      fs   = 1'b1;
      tick();
      fs   = 1'b0;
      wait_req("f2_l0", 25'h2000);
      grant_burst("f2_l0");
      send_beats(32'h200, 1, 0);
      base = 25'h3000;
      fs   = 1'b1;
      tick();
      fs   = 1'b0;
      send_beats(32'h201, 1, 0);
      base = 25'h1000;
      fs   = 1'b1;
      tick();
      fs   = 1'b0;
      send_beats(32'h202, 2, 0);
      chk("pend_beats_in", 64'(bus.pix_valid), 64'd1);
      tick();
      chk("flush_empty", 64'(bus.pix_valid), 64'd0);
      chk("restart_busy", 64'(busy), 64'd1);
      chk("restart_line_cnt", 64'(dut.r_line_cnt), 64'd0);
      wait_req("f3_l0", 25'h1000);
      grant_burst("f3_l0");

      // beat arriving with FIFO full is dropped but still counted
      send_beats(32'h300, 1, 0);
      force dut.w_fifo_full = 1'b1;
      send_beats(32'h301, 1, 0);
      release dut.w_fifo_full;
      chk("ovf_set", 64'(ovf), 64'd1);
      send_beats(32'h302, 2, 0);
      bus.pix_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("ovf_pop", 64'(bus.pix_data), (i == 0) ? 64'h300 : 64'(32'h301 + 32'(i)));
         tick();
      end
      bus.pix_ready = 1'b0;
      chk("ovf_drop_empty", 64'(bus.pix_valid), 64'd0);
      chk("ovf_sticky", 64'(ovf), 64'd1);
      wait_req("f3_l1", 25'h01A00);

      // abort while requesting
      base = 25'h4000;
      fs   = 1'b1;
      tick();
      fs   = 1'b0;
      chk("abort_req", 64'(bus.rd_mem_req), 64'd0);
      chk("abort_ovf_clr", 64'(ovf), 64'd0);
      chk("abort_busy", 64'(busy), 64'd1);
      bus.pix_ready = 1'b1;
      tick();
      chk("udr_set", 64'(udr), 64'd1);
      wait_req("f4_l0", 25'h4000);
      grant_burst("f4_l0");
      send_beats(32'h400, 2, 2);
      chk("udr_sticky", 64'(udr), 64'd1);

      // asynchronous reset mid-burst
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_req", 64'(bus.rd_mem_req), 64'd0);
      chk("arst_addr", 64'(bus.rd_mem_addr), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_udr", 64'(udr), 64'd0);
      chk("arst_pix_valid", 64'(bus.pix_valid), 64'd0);
      tick();
      rst_n = 1'b1;
      bus.pix_ready = 1'b0;
      send_beats(32'h500, 2, 0);
      chk("stray_pix_valid", 64'(bus.pix_valid), 64'd0);
      chk("stray_busy", 64'(busy), 64'd0);
      chk("stray_req", 64'(bus.rd_mem_req), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
